lc3b_pmem_responder: RTL and testbench
======================================

Name: lc3b_pmem_responder

Overview:
- Physical-memory-side responder for the mp2 cache's 128-bit block interface: it answers `pmem_read`/`pmem_write` requests from the cache controller with a single-cycle `pmem_resp` after a fixed latency.
- Holds a small register-based block store indexed by the block address (address bits above the 16-byte offset).
- Used as the memory endpoint in cache bring-up and in regression benches in place of the behavioural memory.

Parameters:
- `LATENCY`, 4, cycles from request acceptance to `pmem_resp`; legal range 1..15.
- `DEPTH_LOG2`, 4, log2 of the number of 128-bit blocks stored (default 16 blocks).

Ports:
- `clk`  input  1  system clock, all state on rising edge
- `reset`  input  1  asynchronous, active-high reset
- `pmem_read`  input  1  cache requests a block read; held until `pmem_resp`
- `pmem_write`  input  1  cache requests a block write; held until `pmem_resp`
- `pmem_address`  input  16  byte address; bits [3:0] ignored (block aligned)
- `pmem_wdata`  input  128  write block (`lc3b_block`)
- `pmem_rdata`  output  128  read block, valid in the `pmem_resp` cycle of a read
- `pmem_resp`  output  1  one-cycle completion strobe
- `busy`  output  1  high while a request is in flight (states BUSY, RESP)
- `proto_err`  output  1  sticky: `pmem_read` and `pmem_write` were seen high together in IDLE

Behaviour:
- Clock and reset: one clock, `clk`; reset is asynchronous and active-high, on port `reset`.
- Reset values:
  - FSM returns to IDLE, `pmem_resp`=0, `busy`=0, `proto_err`=0, `pmem_rdata`=0.
  - All storage blocks are cleared to 0.
  - Latched address, data, op and the counter are cleared.
- Block index: `idx` = `pmem_address`[3+DEPTH_LOG2:4]. Higher address bits are ignored, so addresses alias modulo `DEPTH` blocks.
- FSM states IDLE, BUSY, RESP.
  - IDLE:
    - If `pmem_read` | `pmem_write`: latch `idx`, `pmem_wdata` and op.
    - Op is write if `pmem_write`=1, otherwise read. Write wins if both are high; in that case also set `proto_err`.
    - Load counter with LATENCY-1. Go to BUSY if LATENCY>1, else go to RESP.
  - BUSY:
    - Decrement the counter.
    - When the counter reaches 1 on this edge, go to RESP. `pmem_resp` is therefore asserted exactly LATENCY cycles after the acceptance edge.
  - RESP:
    - `pmem_resp`=1 for exactly one cycle.
    - Read: `pmem_rdata` = store[`idx`], registered on entry to RESP.
    - Write: store[`idx`] <= latched wdata on the RESP exit edge.
    - Always return to IDLE.
- Latching rule: inputs are sampled only at acceptance. Changes to address, data or request lines during BUSY/RESP are ignored, and dropping the request mid-flight does not abort it.
- Back-to-back requests: a request still high in the IDLE cycle after RESP is accepted as a new request. Minimum spacing between `pmem_resp` pulses is LATENCY+1 cycles.
- `pmem_rdata`: holds its last read value between reads; it is not updated by writes.
- Read after write: a read to the same block immediately after a write's `pmem_resp` returns the newly written data.
- `proto_err`: cleared only by `reset`.
- Reset mid-operation: the in-flight op is discarded, no `pmem_resp` is issued, and a pending write is not committed.

Test Plan:
- Reset, then read `addr`=16'h0040 with LATENCY=4 -> `pmem_resp` pulses for 1 cycle, 4 cycles after acceptance; `pmem_rdata`=128'h0; `busy` high for 4 cycles.
- Write 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0 to 16'h0130, then read 16'h0130 -> read returns identical data.
- Aliasing and offset: write block to 16'h0010, then read 16'h0110 (DEPTH=16) -> same data returned; a read of 16'h001F also returns it.
- Change `pmem_address` and `pmem_wdata` during BUSY of a write to 16'h0020 -> store updated at block 2 only, with the originally latched data.
- Assert read and write together on 16'h0050 -> treated as write; `proto_err`=1 and it stays 1 through later good transactions.
- Assert `reset` during BUSY of a write to 16'h0060 -> no `pmem_resp`; a subsequent read of 16'h0060 returns 0. Repeat with LATENCY=1 -> `pmem_resp` appears 1 cycle after acceptance.

Source files
------------

// File: rtl/lc3b_pmem_responder.sv
// Physical-memory responder for the mp2 cache block interface.
// Answers one block read/write at a time with a one-cycle pmem_resp after LATENCY cycles.
module lc3b_pmem_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         busy,
  output logic         proto_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state, state_next;
  logic [DEPTH_LOG2-1:0] idx_in, idx_q, rd_idx;
  logic [127:0]          wdata_q;
  logic                  op_write_q;
  logic [3:0]            count_q;
  logic [127:0]          store [DEPTH];
  logic                  accept, enter_resp, rd_op;
  logic                  unused_addr_bits;

  assign idx_in           = pmem_address[3+DEPTH_LOG2:4];
  assign unused_addr_bits = ^pmem_address;
  assign accept           = (state == IDLE) && (pmem_read || pmem_write);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (LATENCY > 1) ? BUSY : RESP;
      BUSY: if (count_q == 4'd1) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With LATENCY=1 RESP is entered straight from IDLE, so the read must use the live inputs.
  assign enter_resp = (state_next == RESP) && (state != RESP);
  assign rd_idx     = (state == IDLE) ? idx_in : idx_q;
  assign rd_op      = (state == IDLE) ? !pmem_write : !op_write_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx_q      <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
      count_q    <= '0;
      pmem_rdata <= '0;
      proto_err  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        idx_q      <= idx_in;
        wdata_q    <= pmem_wdata;
        op_write_q <= pmem_write;
        count_q    <= 4'(LATENCY - 1);
        if (pmem_read && pmem_write) proto_err <= 1'b1;
      end else if (state == BUSY) begin
        count_q <= count_q - 4'd1;
      end
      if (enter_resp && rd_op) pmem_rdata <= store[rd_idx];
    end
  end

  // Writes commit as RESP is left, so a reset before then discards them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else if (state == RESP && op_write_q) begin
      store[idx_q] <= wdata_q;
    end
  end

  assign pmem_resp = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_lc3b_pmem_responder.sv
// Scoreboard bench for lc3b_pmem_responder: randomized block traffic against an array model,
// plus a second instance built with LATENCY=1.
module tb_lc3b_pmem_responder;

  localparam int LAT   = 4;
  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pmem_read = 1'b0, pmem_write = 1'b0;
  logic [15:0]  pmem_address = '0;
  logic [127:0] pmem_wdata = '0;
  logic [127:0] pmem_rdata;
  logic         pmem_resp, busy, proto_err;

  logic         b_read = 1'b0, b_write = 1'b0;
  logic [15:0]  b_address = '0;
  logic [127:0] b_wdata = '0;
  logic [127:0] b_rdata;
  logic         b_resp, b_busy, b_proto_err;

  always #5 clk = ~clk;

  lc3b_pmem_responder #(.LATENCY(LAT), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset(reset), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .busy(busy), .proto_err(proto_err)
  );

  lc3b_pmem_responder #(.LATENCY(1), .DEPTH_LOG2(DL)) dut_l1 (
    .clk(clk), .reset(reset), .pmem_read(b_read), .pmem_write(b_write),
    .pmem_address(b_address), .pmem_wdata(b_wdata), .pmem_rdata(b_rdata),
    .pmem_resp(b_resp), .busy(b_busy), .proto_err(b_proto_err)
  );

  typedef struct {
    bit           is_write;
    logic [127:0] data;
    int unsigned  due;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [127:0] model_mem [DEPTH];
  logic [127:0] model_rdata;
  bit           model_perr;
  int unsigned  cyc = 0;
  int           errors = 0;
  int           checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!reset && pmem_resp) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_resp", 128'd1, 128'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("resp_cycle", 128'(cyc), 128'(mon_e.due));
        checkOutput(mon_e.is_write ? "rdata_held" : "rdata", pmem_rdata, mon_e.data);
      end
    end
  end

  task automatic clearModel();
    sb.delete();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_rdata = '0;
    model_perr  = 1'b0;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    pmem_read = 1'b0; pmem_write = 1'b0;
    b_read = 1'b0; b_write = 1'b0;
    clearModel();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Called on a falling edge; b2b means the DUT is in its RESP cycle right now.
  task automatic applyStimulus(input bit do_rd, input bit do_wr, input logic [15:0] a,
                               input logic [127:0] d, input bit b2b, input bit wiggle);
    exp_t          e;
    int unsigned   acc;
    int            n, busy_cnt;
    logic [DL-1:0] i;
    i   = a[3+DL:4];
    acc = b2b ? cyc + 2 : cyc + 1;
    pmem_read = do_rd; pmem_write = do_wr; pmem_address = a; pmem_wdata = d;
    if (do_wr) begin
      e.is_write = 1'b1;
      e.data     = model_rdata;
      model_mem[i] = d;
      if (do_rd) model_perr = 1'b1;
    end else begin
      model_rdata = model_mem[i];
      e.is_write  = 1'b0;
      e.data      = model_rdata;
    end
    e.due = acc + LAT - 1;
    sb.push_back(e);
    n = 0; busy_cnt = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) busy_cnt++;
      if (wiggle && !pmem_resp && cyc >= acc) begin
        pmem_address = 16'($urandom);
        pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
        pmem_read    = 1'($urandom);
        pmem_write   = 1'($urandom);
      end
    end while (!pmem_resp && n < 40);
    if (!pmem_resp) begin
      checkOutput("resp_timeout", 128'd0, 128'd1);
      sb.delete();
    end else begin
      checkOutput("busy_cycles", 128'(busy_cnt), 128'(LAT));
      checkOutput("proto_err", 128'(proto_err), 128'(model_perr));
    end
    pmem_read = 1'b0; pmem_write = 1'b0;
  endtask

  // LATENCY=1 instance: response must land in the cycle right after acceptance.
  task automatic bTransaction(input bit do_wr, input logic [15:0] a, input logic [127:0] d,
                              input logic [127:0] exp_rdata);
    int unsigned acc;
    int          n;
    acc = cyc + 1;
    b_read = !do_wr; b_write = do_wr; b_address = a; b_wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_resp && n < 20);
    checkOutput("l1_resp_seen", 128'(b_resp), 128'd1);
    checkOutput("l1_resp_cycle", 128'(cyc), 128'(acc));
    checkOutput("l1_rdata", b_rdata, exp_rdata);
    b_read = 1'b0; b_write = 1'b0;
    @(negedge clk);
    checkOutput("l1_resp_one_cycle", 128'(b_resp), 128'd0);
  endtask

  initial begin
    logic [127:0] d;
    bit           prev_b2b;
    int           op;
    applyReset();
    checkOutput("reset_rdata", pmem_rdata, 128'd0);
    checkOutput("reset_resp", 128'(pmem_resp), 128'd0);
    checkOutput("reset_busy", 128'(busy), 128'd0);
    checkOutput("reset_proto_err", 128'(proto_err), 128'd0);

    applyStimulus(1, 0, 16'h0040, '0, 0, 0);
    @(negedge clk);
    d = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0;
    applyStimulus(0, 1, 16'h0130, d, 0, 0);
    @(negedge clk);
    applyStimulus(1, 0, 16'h0130, '0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 1, 16'h0010, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, 0);
    applyStimulus(1, 0, 16'h0110, '0, 1, 0);
    @(negedge clk);
    applyStimulus(1, 0, 16'h001F, '0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 1, 16'h0020, 128'hA5A5_0000_FFFF_1234_0000_5678_9ABC_DEF0, 0, 1);
    @(negedge clk);
    applyStimulus(1, 0, 16'h0020, '0, 0, 0);
    @(negedge clk);
    applyStimulus(1, 0, 16'h0030, '0, 0, 0);
    @(negedge clk);
    applyStimulus(1, 1, 16'h0050, 128'hCAFE_F00D_0000_0001_0000_0002_0000_0003, 0, 0);
    @(negedge clk);
    applyStimulus(1, 0, 16'h0050, '0, 0, 0);

    prev_b2b = 1'b0;
    for (int t = 0; t < 150; t++) begin
      prev_b2b = ($urandom_range(0, 3) == 0);
      if (!prev_b2b) repeat ($urandom_range(1, 3)) @(negedge clk);
      op = $urandom_range(0, 9);
      d  = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(op < 1 || op > 4, op < 5, 16'($urandom), d, prev_b2b,
                    1'($urandom_range(0, 1)));
    end
    checkOutput("proto_err_sticky", 128'(proto_err), 128'd1);

    @(negedge clk);
    pmem_write = 1'b1; pmem_address = 16'h0060; pmem_wdata = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
    repeat (2) @(negedge clk);
    checkOutput("busy_midflight", 128'(busy), 128'd1);
    #2;
    reset = 1'b1;
    pmem_write = 1'b0;
    clearModel();
    repeat (3) begin
      @(negedge clk);
      checkOutput("resp_during_reset", 128'(pmem_resp), 128'd0);
    end
    reset = 1'b0;
    @(negedge clk);
    checkOutput("after_abort_busy", 128'(busy), 128'd0);
    checkOutput("after_abort_proto_err", 128'(proto_err), 128'd0);
    applyStimulus(1, 0, 16'h0060, '0, 0, 0);
    @(negedge clk);
    checkOutput("no_stray_resp", 128'(sb.size()), 128'd0);

    applyReset();
    checkOutput("l1_reset_busy", 128'(b_busy), 128'd0);
    bTransaction(1, 16'h0060, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'd0);
    bTransaction(0, 16'h0060, '0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    bTransaction(0, 16'h0070, '0, 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
